// File: rtl/buzzer_pkg.sv
// Shared tables and types for the buzzer sequencer: per-source tone and beep
// count, the sequencer state encoding and a fixed-priority pick helper.
package buzzer_pkg;

    localparam int NUM_SRC = 4;
    localparam int TONE_W  = 17;
    localparam int BEEP_W  = 3;
    localparam int TICK_W  = 16;

    // Half-period toggle counts for 440, 659, 880 and 1320 Hz at 100 MHz.
    localparam logic [TONE_W-1:0] TONE_LIMIT [NUM_SRC] = '{
        17'd113636, 17'd75843, 17'd56818, 17'd37878
    };

    // Number of beeps in each source's pattern.
    localparam logic [BEEP_W-1:0] BEEP_COUNT [NUM_SRC] = '{
        3'd1, 3'd2, 3'd3, 3'd5
    };

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARB      = 3'd1,
        BEEP_ON  = 3'd2,
        BEEP_OFF = 3'd3,
        GAP      = 3'd4
    } state_e;

    // Index of the lowest set bit; index 0 has the highest priority.
    // Returns 0 for an all-zero vector, callers only use it when a bit is set.
    function automatic logic [1:0] lowest_index(input logic [NUM_SRC-1:0] vec);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/buzzer_sequencer_tick_timer.sv
// Duration timer for the buzzer sequencer: a clock prescaler that produces
// ticks, followed by a tick counter. expire_o is high for the last clock of
// a length_i-tick interval. clear_i restarts the interval from zero so every
// phase of a beep pattern is measured from its own first cycle.
module tick_timer
    import buzzer_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [TICK_W-1:0] length_i,
    output logic              expire_o
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  preCount_q;
    logic [PRE_W-1:0]  preCount_d;
    logic [TICK_W-1:0] tickCount_q;
    logic [TICK_W-1:0] tickCount_d;
    logic              preWrap;

    // Last clock of the final tick of the requested interval.
    assign preWrap  = (preCount_q == PRE_LAST);
    assign expire_o = preWrap && (tickCount_q == (length_i - TICK_W'(1)));

    // Advance the prescaler every clock and the tick counter on each wrap.
    always_comb begin
        preCount_d  = preCount_q;
        tickCount_d = tickCount_q;
        if (clear_i) begin
            preCount_d  = '0;
            tickCount_d = '0;
        end else if (preWrap) begin
            preCount_d  = '0;
            tickCount_d = tickCount_q + TICK_W'(1);
        end else begin
            preCount_d  = preCount_q + PRE_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            preCount_q  <= '0;
            tickCount_q <= '0;
        end else begin
            preCount_q  <= preCount_d;
            tickCount_q <= tickCount_d;
        end
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// Buzzer sequencer: latches one-cycle alarm requests, grants the shared tone
// generator to the lowest-numbered pending source and plays that source's
// beep pattern (tone, beep count, on/off timing) followed by a quiet gap.
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int ON_TICKS  = 200,
    parameter int OFF_TICKS = 150,
    parameter int GAP_TICKS = 300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic              cancel,
    output logic              buzzer_on,
    output logic [TONE_W-1:0] tone_limit,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic              done
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    state_e              state_q;
    logic [NUM_REQ-1:0]  pending_q;
    logic [NUM_REQ-1:0]  pending_d;
    logic [1:0]          grant_q;
    logic [BEEP_W-1:0]   beepsLeft_q;
    logic                buzzer_q;
    logic [TONE_W-1:0]   tone_q;
    logic                busy_q;
    logic                done_q;

    logic [1:0]          arbIdx;
    logic                takeGrant;
    logic                timerClear;
    logic [TICK_W-1:0]   timerLength;
    logic                timerExpire;

    assign buzzer_on  = buzzer_q;
    assign tone_limit = tone_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Pick the winner among latched requests and fold in new request pulses;
    // a new pulse for the source being granted re-arms it for a replay.
    always_comb begin
        arbIdx    = lowest_index(pending_q);
        takeGrant = (state_q == IDLE) && (|pending_q);
        pending_d = pending_q | req;
        if (takeGrant) begin
            pending_d = (pending_q & ~(NUM_REQ'(1) << arbIdx)) | req;
        end
    end

    // Select the interval for the current phase and restart the timer on
    // every phase change so each phase lasts exactly its programmed time.
    always_comb begin
        case (state_q)
            BEEP_OFF: timerLength = TICK_W'(OFF_TICKS);
            GAP:      timerLength = TICK_W'(GAP_TICKS);
            default:  timerLength = TICK_W'(ON_TICKS);
        endcase
        timerClear = rst || cancel || (state_q == IDLE) || (state_q == ARB)
                     || timerExpire;
    end

    tick_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timerClear),
        .length_i (timerLength),
        .expire_o (timerExpire)
    );

    // Sequencer FSM with registered outputs. The grant is taken on the edge
    // into ARB so grant_id is already valid for the whole busy window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            grant_q     <= '0;
            beepsLeft_q <= '0;
            buzzer_q    <= 1'b0;
            tone_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (cancel) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            grant_q     <= '0;
            beepsLeft_q <= '0;
            buzzer_q    <= 1'b0;
            tone_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (takeGrant) begin
                        state_q     <= ARB;
                        grant_q     <= arbIdx;
                        beepsLeft_q <= BEEP_COUNT[arbIdx];
                        busy_q      <= 1'b1;
                    end
                end
                ARB: begin
                    state_q  <= BEEP_ON;
                    buzzer_q <= 1'b1;
                    tone_q   <= TONE_LIMIT[grant_q];
                end
                BEEP_ON: begin
                    if (timerExpire) begin
                        buzzer_q <= 1'b0;
                        tone_q   <= '0;
                        if (beepsLeft_q > BEEP_W'(1)) begin
                            beepsLeft_q <= beepsLeft_q - BEEP_W'(1);
                            state_q     <= BEEP_OFF;
                        end else begin
                            state_q     <= GAP;
                        end
                    end
                end
                BEEP_OFF: begin
                    if (timerExpire) begin
                        state_q  <= BEEP_ON;
                        buzzer_q <= 1'b1;
                        tone_q   <= TONE_LIMIT[grant_q];
                    end
                end
                GAP: begin
                    if (timerExpire) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    buzzer_q <= 1'b0;
                    tone_q   <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
